// File: rtl/endpoint_bus_master_if.sv
// endpoint_bus_master_if: peripheral bus between the send-side initiator and a chiplet endpoint.
//   bus_addr / bus_wdata / bus_strobe : write address, data and byte strobe (master -> slave)
//   bus_wen / bus_ren                 : write / read enable (master -> slave)
//   bus_rdata                         : read data (slave -> master)
//   bus_error                         : transaction error, valid at completion (slave -> master)
//   bus_request_stall                 : slave not ready; holds the current transaction
interface endpoint_bus_master_if;
  logic [31:0] bus_addr;
  logic        bus_wen;
  logic        bus_ren;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_strobe;
  logic [31:0] bus_rdata;
  logic        bus_error;
  logic        bus_request_stall;

  modport master (
    output bus_addr, bus_wen, bus_ren, bus_wdata, bus_strobe,
    input  bus_rdata, bus_error, bus_request_stall
  );

  modport slave (
    input  bus_addr, bus_wen, bus_ren, bus_wdata, bus_strobe,
    output bus_rdata, bus_error, bus_request_stall
  );
endinterface

// File: rtl/endpoint_bus_master.sv
// endpoint_bus_master: send-only bus initiator for a chiplet endpoint. Each command streams its
// payload into the TX cache window, programs the message's packet start-address slot and then
// writes the message id to the TX send register.
//   clk, n_rst                         : clock, asynchronous active-low reset
//   cmd_valid/cmd_ready                : command handshake (cmd_msg_id, cmd_offset, cmd_len)
//   data_valid/data_ready, data_word   : payload word stream
//   busy                               : command in flight
//   done                               : one-cycle pulse, send triggered
//   err, err_code                      : one-cycle pulse, command aborted (1 range, 2 bus error)
//   bus                                : peripheral bus, master side
module endpoint_bus_master #(
  parameter int unsigned NUM_MSGS  = 4,
  parameter int unsigned MAX_WORDS = 128,
  localparam int unsigned MID_W    = $clog2(NUM_MSGS),
  localparam int unsigned LEN_W    = $clog2(MAX_WORDS + 1)
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [MID_W-1:0]     cmd_msg_id,
  input  logic [8:0]           cmd_offset,
  input  logic [LEN_W-1:0]     cmd_len,
  input  logic                 data_valid,
  output logic                 data_ready,
  input  logic [31:0]          data_word,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [1:0]           err_code,
  endpoint_bus_master_if.master bus
);

  // Range check width: wide enough that offset + 4*len never wraps.
  localparam int unsigned ChkW = (LEN_W + 3 > 11) ? LEN_W + 3 : 11;

  localparam logic [1:0]  ErrRange = 2'd1;
  localparam logic [1:0]  ErrBus   = 2'd2;
  localparam logic [31:0] CacheBase = 32'h0000_2000;
  localparam logic [31:0] SendAddr  = 32'h0000_1004;

  typedef enum logic [2:0] {StIdle, StData, StPtr, StTrig, StRpt} state_e;

  state_e             state_q, state_d;
  logic [MID_W-1:0]   id_q, id_d;
  logic [8:0]         off_q, off_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   acc_q, acc_d;   // payload words accepted from upstream
  logic [LEN_W-1:0]   cmp_q, cmp_d;   // payload words completed on the bus
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic               wen_q, wen_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [1:0]         code_q, code_d;

  logic [8:0]         off_in;
  logic [ChkW-1:0]    end_byte;
  logic               range_bad;
  logic               complete;
  logic               data_fire;
  logic               unused_in;

  assign off_in    = {cmd_offset[8:2], 2'b00};
  assign end_byte  = ChkW'(off_in) + (ChkW'(cmd_len) << 2);
  assign range_bad = (cmd_len == '0) || (end_byte > ChkW'(512));

  // In DATA the bus register doubles as the one-entry holding register.
  assign complete  = wen_q && !bus.bus_request_stall;

  assign cmd_ready  = n_rst && (state_q == StIdle);
  // Refuse new words on an erroring completion so nothing accepted is dropped.
  assign data_ready = (state_q == StData) && (acc_q < len_q) &&
                      (!wen_q || (complete && !bus.bus_error));
  assign data_fire  = data_valid && data_ready;
  assign busy       = (state_q != StIdle);
  assign done       = done_q;
  assign err        = err_q;
  assign err_code   = code_q;

  assign bus.bus_addr   = addr_q;
  assign bus.bus_wdata  = wdata_q;
  assign bus.bus_wen    = wen_q;
  assign bus.bus_ren    = 1'b0;
  assign bus.bus_strobe = wen_q ? 4'hF : 4'h0;

  assign unused_in = ^{bus.bus_rdata, cmd_offset[1:0]};

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    off_d   = off_q;
    len_d   = len_q;
    acc_d   = acc_q;
    cmp_d   = cmp_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wen_d   = wen_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    code_d  = 2'd0;

    unique case (state_q)
      StIdle: begin
        if (cmd_valid && cmd_ready) begin
          id_d  = cmd_msg_id;
          off_d = off_in;
          len_d = cmd_len;
          acc_d = '0;
          cmp_d = '0;
          if (range_bad) begin
            state_d = StRpt;
            err_d   = 1'b1;
            code_d  = ErrRange;
          end else begin
            state_d = StData;
          end
        end
      end

      StData: begin
        if (complete) begin
          wen_d = 1'b0;
          if (bus.bus_error) begin
            state_d = StRpt;
            err_d   = 1'b1;
            code_d  = ErrBus;
          end else begin
            cmp_d = cmp_q + LEN_W'(1);
            // Last payload word done: load the pointer write straight away.
            if ((cmp_q + LEN_W'(1)) == len_q) begin
              state_d = StPtr;
              addr_d  = 32'({id_q, 2'b00});
              wdata_d = {23'b0, off_q};
              wen_d   = 1'b1;
            end
          end
        end
        if (data_fire) begin
          addr_d  = CacheBase + 32'(off_q) + (32'(acc_q) << 2);
          wdata_d = data_word;
          wen_d   = 1'b1;
          acc_d   = acc_q + LEN_W'(1);
        end
      end

      StPtr: begin
        if (complete) begin
          if (bus.bus_error) begin
            state_d = StRpt;
            wen_d   = 1'b0;
            err_d   = 1'b1;
            code_d  = ErrBus;
          end else begin
            state_d = StTrig;
            addr_d  = SendAddr;
            wdata_d = 32'(id_q);
          end
        end
      end

      StTrig: begin
        if (complete) begin
          wen_d = 1'b0;
          if (bus.bus_error) begin
            state_d = StRpt;
            err_d   = 1'b1;
            code_d  = ErrBus;
          end else begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
        end
      end

      StRpt: state_d = StIdle;

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= StIdle;
      id_q    <= '0;
      off_q   <= '0;
      len_q   <= '0;
      acc_q   <= '0;
      cmp_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wen_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      off_q   <= off_d;
      len_q   <= len_d;
      acc_q   <= acc_d;
      cmp_q   <= cmp_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wen_q   <= wen_d;
      done_q  <= done_d;
      err_q   <= err_d;
      code_q  <= code_d;
    end
  end

endmodule

// File: tb/tb_endpoint_bus_master.sv
module tb_endpoint_bus_master;
  localparam int unsigned NUM_MSGS  = 4;
  localparam int unsigned MAX_WORDS = 128;
  localparam int unsigned MID_W     = 2;
  localparam int unsigned LEN_W     = 8;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [MID_W-1:0]  cmd_msg_id = '0;
  logic [8:0]        cmd_offset = '0;
  logic [LEN_W-1:0]  cmd_len = '0;
  logic              data_valid = 1'b0;
  logic              data_ready;
  logic [31:0]       data_word = '0;
  logic              busy, done, err;
  logic [1:0]        err_code;

  endpoint_bus_master_if bus_if ();

  endpoint_bus_master #(.NUM_MSGS(NUM_MSGS), .MAX_WORDS(MAX_WORDS)) dut (
    .clk(clk), .n_rst(n_rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_msg_id(cmd_msg_id),
    .cmd_offset(cmd_offset), .cmd_len(cmd_len),
    .data_valid(data_valid), .data_ready(data_ready), .data_word(data_word),
    .busy(busy), .done(done), .err(err), .err_code(err_code),
    .bus(bus_if)
  );

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- environment state ----------------
  int          cyc = 0;
  logic [31:0] data_q[$];
  logic [63:0] obs_q[$];
  int          gap_mode = 0;     // 0 always valid, 1 alternate, 2 random
  int          stall_mode = 0;   // 0 none, 1 random, 2 scripted on one address
  logic [31:0] stall_addr = '0;
  int          stall_left = 0;
  bit          err_en = 1'b0;
  logic [31:0] err_addr = '0;
  int          stall_cycles = 0;
  int          done_cnt = 0, err_cnt = 0;
  int          done_cyc = 0, t0 = 0;
  logic [1:0]  last_code = '0;

  always begin
    @(posedge clk);
    cyc++;
  end

  // Payload producer.
  bit fire_p = 1'b0;
  bit ph = 1'b0;
  always begin
    bit v;
    @(negedge clk);
    fire_p = data_valid && data_ready;
    @(posedge clk);
    #1;
    if (fire_p && data_q.size() > 0) void'(data_q.pop_front());
    ph = ~ph;
    case (gap_mode)
      1:       v = ph;
      2:       v = ($urandom_range(0, 2) != 0);
      default: v = 1'b1;
    endcase
    data_valid = (data_q.size() > 0) && v;
    data_word  = data_valid ? data_q[0] : 32'h0;
  end

  // Bus responder: stall and error injection.
  always begin
    logic s;
    @(posedge clk);
    #1;
    s = 1'b0;
    if (stall_mode == 1) s = ($urandom_range(0, 3) == 0);
    else if (stall_mode == 2 && bus_if.bus_wen && bus_if.bus_addr == stall_addr &&
             stall_left > 0) begin
      s = 1'b1;
      stall_left--;
    end
    bus_if.bus_request_stall = s;
    bus_if.bus_error = err_en && bus_if.bus_wen && (bus_if.bus_addr == err_addr);
  end

  // Monitor: protocol rules and write log.
  bit          prev_stall = 1'b0, prev_fire = 1'b0;
  logic [31:0] prev_addr = '0, prev_wdata = '0, prev_word = '0;
  always begin
    @(negedge clk);
    if (!n_rst) begin
      prev_stall = 1'b0;
      prev_fire  = 1'b0;
    end else begin
      check("strobe", 64'(bus_if.bus_strobe), bus_if.bus_wen ? 64'hF : 64'h0);
      check("ren", 64'(bus_if.bus_ren), 64'h0);
      if (prev_fire) begin
        check("word_lag_wen", 64'(bus_if.bus_wen), 64'h1);
        check("word_lag_data", 64'(bus_if.bus_wdata), 64'(prev_word));
      end
      if (prev_stall) begin
        check("hold_wen", 64'(bus_if.bus_wen), 64'h1);
        check("hold_addr", 64'(bus_if.bus_addr), 64'(prev_addr));
        check("hold_wdata", 64'(bus_if.bus_wdata), 64'(prev_wdata));
      end
      if (bus_if.bus_wen && bus_if.bus_request_stall) begin
        check("ready_while_full", 64'(data_ready), 64'h0);
        stall_cycles++;
      end
      if (bus_if.bus_wen && !bus_if.bus_request_stall && !bus_if.bus_error)
        obs_q.push_back({bus_if.bus_addr, bus_if.bus_wdata});
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (err) begin
        err_cnt++;
        last_code = err_code;
      end
      if (cmd_valid && cmd_ready) t0 = cyc;
      prev_stall = bus_if.bus_wen && bus_if.bus_request_stall;
      prev_addr  = bus_if.bus_addr;
      prev_wdata = bus_if.bus_wdata;
      prev_fire  = data_valid && data_ready;
      prev_word  = data_word;
    end
  end

  // One command against the reference model: expected write list, outcome and latency.
  task automatic run_cmd(input int id, input int off, input int len, input bit chk_lat);
    logic [63:0] exp_q[$];
    logic [31:0] w;
    int offc, dc0, ec0, exp_code;
    bit bad, acc, fin, cut;
    offc = off & 32'h1FC;
    bad  = (len == 0) || (offc + 4 * len > 512);
    obs_q.delete();
    data_q.delete();
    if (bad) begin
      data_q.push_back($urandom);
    end else begin
      for (int i = 0; i < len; i++) begin
        w = $urandom;
        data_q.push_back(w);
        exp_q.push_back({32'(32'h2000 + offc + 4 * i), w});
      end
      exp_q.push_back({32'(4 * id), 32'(offc)});
      exp_q.push_back({32'h1004, 32'(id)});
    end
    // A bus error ends the write sequence at the failing transaction.
    cut = 1'b0;
    if (err_en) begin
      for (int i = 0; i < exp_q.size(); i++) begin
        if (exp_q[i][63:32] == err_addr) begin
          cut = 1'b1;
          while (exp_q.size() > i) void'(exp_q.pop_back());
          break;
        end
      end
    end
    exp_code = bad ? 1 : (cut ? 2 : 0);
    stall_cycles = 0;
    @(posedge clk);
    #1;
    dc0 = done_cnt;
    ec0 = err_cnt;
    cmd_valid  = 1'b1;
    cmd_msg_id = MID_W'(id);
    cmd_offset = 9'(off);
    cmd_len    = LEN_W'(len);
    acc = 1'b0;
    for (int k = 0; k < 100 && !acc; k++) begin
      @(negedge clk);
      acc = cmd_ready;
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    check("cmd_accepted", 64'(acc), 64'h1);
    fin = 1'b0;
    for (int k = 0; k < 3000 && !fin; k++) begin
      @(negedge clk);
      #1;
      fin = (done_cnt != dc0) || (err_cnt != ec0);
    end
    check("cmd_finished", 64'(fin), 64'h1);
    check("done_count", 64'(done_cnt - dc0), (exp_code == 0) ? 64'h1 : 64'h0);
    check("err_count", 64'(err_cnt - ec0), (exp_code == 0) ? 64'h0 : 64'h1);
    if (exp_code != 0) check("err_code", 64'(last_code), 64'(exp_code));
    if (exp_code == 0 && chk_lat)
      check("done_latency", 64'(done_cyc - t0), 64'(len + 4 + stall_cycles));
    check("write_count", 64'(obs_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      check("write_entry", obs_q[i], exp_q[i]);
    if (bad) check("reject_no_consume", 64'(data_q.size()), 64'h1);
    @(negedge clk);
    check("ready_after", 64'(cmd_ready), 64'h1);
    check("idle_after", 64'(busy), 64'h0);
  endtask

  initial begin
    bit got;
    bus_if.bus_rdata = 32'h0;
    bus_if.bus_error = 1'b0;
    bus_if.bus_request_stall = 1'b0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_wen", 64'(bus_if.bus_wen), 64'h0);
    check("rst_addr", 64'(bus_if.bus_addr), 64'h0);
    check("rst_wdata", 64'(bus_if.bus_wdata), 64'h0);
    check("rst_outs", 64'({done, err, err_code, busy, data_ready, cmd_ready}), 64'h0);
    @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    check("rst_release_ready", 64'(cmd_ready), 64'h1);

    // Basic send and stalled send.
    run_cmd(2, 'h40, 3, 1'b1);
    stall_mode = 2; stall_addr = 32'h2044; stall_left = 3;
    run_cmd(2, 'h40, 3, 1'b1);
    check("stall_used", 64'(stall_cycles), 64'h3);
    stall_mode = 0;

    // Range checks.
    run_cmd(1, 'h10, 0, 1'b1);
    run_cmd(3, 'h1F8, 3, 1'b1);
    run_cmd(3, 'h1F8, 2, 1'b1);
    run_cmd(0, 'h1FF, 1, 1'b1);

    // Bus error on the pointer write and on a payload word.
    err_en = 1'b1; err_addr = 32'h8;
    run_cmd(2, 'h40, 3, 1'b1);
    err_addr = 32'h2044;
    run_cmd(1, 'h40, 4, 1'b1);
    err_en = 1'b0;

    // Alternating data gaps.
    gap_mode = 1;
    run_cmd(1, 'h100, 4, 1'b0);
    gap_mode = 0;

    // Reset mid-payload.
    obs_q.delete();
    data_q.delete();
    for (int i = 0; i < 5; i++) data_q.push_back($urandom);
    @(posedge clk);
    #1;
    cmd_valid = 1'b1; cmd_msg_id = 2'd3; cmd_offset = 9'h20; cmd_len = 8'd5;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge clk);
      #1;
      got = (obs_q.size() >= 2);
    end
    check("mid_reset_progress", 64'(got), 64'h1);
    @(posedge clk);
    #1;
    n_rst = 1'b0;
    #1;
    check("mid_rst_wen", 64'(bus_if.bus_wen), 64'h0);
    check("mid_rst_addr", 64'(bus_if.bus_addr), 64'h0);
    check("mid_rst_wdata", 64'(bus_if.bus_wdata), 64'h0);
    check("mid_rst_outs", 64'({done, err, busy, data_ready, cmd_ready}), 64'h0);
    data_q.delete();
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    repeat (2) @(negedge clk);
    check("mid_rst_no_trigger", 64'(obs_q.size()), 64'h2);
    run_cmd(3, 'h20, 5, 1'b1);

    // Randomised commands.
    for (int n = 0; n < 25; n++) begin
      int id, off, len;
      id  = $urandom_range(0, NUM_MSGS - 1);
      off = $urandom_range(0, 511);
      len = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 130) : $urandom_range(0, 12);
      gap_mode   = ($urandom_range(0, 1) == 0) ? 0 : 2;
      stall_mode = $urandom_range(0, 1);
      err_en     = ($urandom_range(0, 4) == 0);
      err_addr   = ($urandom_range(0, 1) == 0) ? 32'(4 * id) : 32'h1004;
      run_cmd(id, off, len, gap_mode == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end
endmodule
